// File: rtl/rv_pkg.sv
// Shared ready/valid stream constants and types for the ingress path.
package rv_pkg;
    localparam int BYTE_W    = 8;
    localparam int DEF_RATIO = 4;
    typedef logic [$clog2(DEF_RATIO)-1:0] lane_t;
endpackage

// File: rtl/byte_word_packer_if.sv
// Byte ingress / word egress stream bundle for byte_word_packer.
interface byte_word_packer_if
    import rv_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int RATIO  = DEF_RATIO
);
    logic                      i_valid;
    logic                      i_ready;
    logic [DATA_W-1:0]         i_data;
    logic                      i_last;
    logic                      e_valid;
    logic                      e_ready;
    logic [DATA_W*RATIO-1:0]   e_data;
    logic [RATIO-1:0]          e_keep;
    logic                      e_last;

    // slave: the packer's view; master: the environment driving it
    modport slave  (input  i_valid, i_data, i_last, e_ready,
                    output i_ready, e_valid, e_data, e_keep, e_last);
    modport master (output i_valid, i_data, i_last, e_ready,
                    input  i_ready, e_valid, e_data, e_keep, e_last);
endinterface

// File: rtl/byte_word_packer.sv
// Packs RATIO little-endian bytes into one registered word with keep bits;
// short tail words at packet end are zero-filled.
module byte_word_packer
    import rv_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int RATIO  = DEF_RATIO
) (
    input  logic               clk,
    input  logic               rst,
    byte_word_packer_if.slave  bus
);
    localparam int LANE_W = $clog2(RATIO);

    logic [LANE_W-1:0]               lane;
    logic [RATIO-2:0][DATA_W-1:0]    acc_data;
    logic [RATIO-2:0]                acc_keep;
    logic [RATIO-1:0][DATA_W-1:0]    word_data;
    logic [RATIO-1:0]                word_keep;
    logic                            accept;
    logic                            done;

    assign bus.i_ready = rst && (!bus.e_valid || bus.e_ready);
    assign accept      = bus.i_valid && bus.i_ready;
    assign done        = accept && ((lane == LANE_W'(RATIO-1)) || bus.i_last);

    // Accumulator merged with the byte in flight; lanes above `lane` stay zero
    always_comb begin
        word_data = '0;
        word_keep = '0;
        for (int k = 0; k < RATIO-1; k++) begin
            word_data[k] = acc_data[k];
            word_keep[k] = acc_keep[k];
        end
        for (int k = 0; k < RATIO; k++) begin
            if (lane == LANE_W'(k)) begin
                word_data[k] = bus.i_data;
                word_keep[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane        <= '0;
            acc_data    <= '0;
            acc_keep    <= '0;
            bus.e_valid <= 1'b0;
            bus.e_data  <= '0;
            bus.e_keep  <= '0;
            bus.e_last  <= 1'b0;
        end else begin
            if (bus.e_ready)
                bus.e_valid <= 1'b0;
            // a completing word overrides the pop clear so back-to-back words have no bubble
            if (done) begin
                bus.e_valid <= 1'b1;
                bus.e_data  <= word_data;
                bus.e_keep  <= word_keep;
                bus.e_last  <= bus.i_last;
                lane        <= '0;
                acc_data    <= '0;
                acc_keep    <= '0;
            end else if (accept) begin
                for (int k = 0; k < RATIO-1; k++) begin
                    if (lane == LANE_W'(k)) begin
                        acc_data[k] <= bus.i_data;
                        acc_keep[k] <= 1'b1;
                    end
                end
                lane <= lane + LANE_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_byte_word_packer.sv
// Random + directed bench for byte_word_packer with a queue-based packing model.
module tb_byte_word_packer;
    localparam int DW = 8;
    localparam int R  = 4;

    typedef struct {
        logic [DW*R-1:0] d;
        logic [R-1:0]    k;
        logic            l;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    byte_word_packer_if #(.DATA_W(DW), .RATIO(R)) bus ();
    byte_word_packer #(.DATA_W(DW), .RATIO(R)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;

    word_t exp_q[$];
    logic [DW*R-1:0] m_data;
    logic [R-1:0]    m_keep;
    int              m_n;
    logic            hold;
    logic [DW*R-1:0] hold_d;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Spec-level model: bytes fill lanes in order, word closes at RATIO bytes or last
    always @(negedge clk) begin
        if (!rst) begin
            m_data = '0; m_keep = '0; m_n = 0; hold = 1'b0;
            exp_q.delete();
        end else begin
            if (hold) begin
                chk("hold_valid", bus.e_valid, 1);
                chk("hold_data", bus.e_data, hold_d);
            end
            if (bus.e_valid && !bus.e_ready)
                chk("stall_iready", bus.i_ready, 0);
            if (bus.e_valid && bus.e_ready) begin
                if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
                else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("sb_data", bus.e_data, w.d);
                    chk("sb_keep", bus.e_keep, w.k);
                    chk("sb_last", bus.e_last, w.l);
                end
            end
            hold   = bus.e_valid && !bus.e_ready;
            hold_d = bus.e_data;
            if (bus.i_valid && bus.i_ready) begin
                m_data = m_data | ((DW*R)'(bus.i_data) << (DW*m_n));
                m_keep = m_keep | R'(1 << m_n);
                m_n++;
                if (m_n == R || bus.i_last) begin
                    exp_q.push_back('{d: m_data, k: m_keep, l: bus.i_last});
                    m_data = '0; m_keep = '0; m_n = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input bit rand_er);
        int  waited = 0;
        bit  ok     = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = l;
        while (!ok) begin
            if (rand_er) bus.e_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.i_ready) ok = 1;
            else begin
                stalls++;
                waited++;
                if (waited > 200) begin
                    chk("send_timeout", 1, 0);
                    ok = 1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h5A;
        bus.i_last  = 1'b0;
        bus.e_ready = 1'b1;

        // Reset held with traffic offered
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_evalid", bus.e_valid, 0);
            chk("rst_edata", bus.e_data, 0);
            chk("rst_ekeep", bus.e_keep, 0);
            chk("rst_elast", bus.e_last, 0);
            chk("rst_iready", bus.i_ready, 0);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_iready", bus.i_ready, 1);
        chk("rel_evalid", bus.e_valid, 0);
        @(posedge clk); #1;

        // Full word, visible right after the fourth accept
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 0, 0);
        send_byte(8'h44, 1, 0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("full_evalid", bus.e_valid, 1);
        chk("full_edata", bus.e_data, 32'h44332211);
        chk("full_ekeep", bus.e_keep, 4'b1111);
        chk("full_elast", bus.e_last, 1);
        @(posedge clk); #1;
        idle(2);

        // Tail word
        send_byte(8'hAA, 0, 0);
        send_byte(8'hBB, 0, 0);
        send_byte(8'hCC, 0, 0);
        send_byte(8'hDD, 0, 0);
        send_byte(8'hEE, 1, 0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("tail_edata", bus.e_data, 32'h000000EE);
        chk("tail_ekeep", bus.e_keep, 4'b0001);
        @(posedge clk); #1;
        idle(2);

        // Backpressure: word held, next byte offered but stalled
        bus.e_ready = 1'b0;
        send_byte(8'h01, 0, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h04, 1, 0);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h05;
        bus.i_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_iready", bus.i_ready, 0);
            chk("bp_evalid", bus.e_valid, 1);
            chk("bp_edata", bus.e_data, 32'h04030201);
            @(posedge clk); #1;
        end
        bus.e_ready = 1'b1;
        send_byte(8'h05, 1, 0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("b2b_evalid", bus.e_valid, 1);
        chk("b2b_edata", bus.e_data, 32'h00000005);
        @(posedge clk); #1;
        idle(2);

        // Streaming at full rate
        stalls = 0;
        for (int i = 0; i < 64; i++)
            send_byte(8'($urandom), (i == 63) ? 1'b1 : 1'($urandom_range(0, 7) == 0), 0);
        bus.i_valid = 1'b0;
        chk("stream_stalls", stalls, 0);
        idle(3);

        // Reset mid-word discards the partial word
        send_byte(8'hF1, 0, 0);
        send_byte(8'hF2, 0, 0);
        bus.i_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        send_byte(8'hA1, 0, 0);
        send_byte(8'hA2, 0, 0);
        send_byte(8'hA3, 0, 0);
        send_byte(8'hA4, 1, 0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("mid_edata", bus.e_data, 32'hA4A3A2A1);
        chk("mid_ekeep", bus.e_keep, 4'b1111);
        @(posedge clk); #1;
        idle(2);

        // Random traffic with random egress backpressure
        for (int i = 0; i < 200; i++)
            send_byte(8'($urandom), (i == 199) ? 1'b1 : 1'($urandom_range(0, 4) == 0), 1);
        bus.i_valid = 1'b0;
        bus.e_ready = 1'b1;
        idle(10);
        chk("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
